// File: rtl/lamp_guard_if.sv
// Lamp guard bus: upstream lamp code and clear request in,
// checked lamp drive and fault status out.
interface lamp_guard_if;
    logic [0:2] light;
    logic       clear_fault;
    logic [0:2] lamp;
    logic       fault;
    logic [1:0] fault_code;
    logic [7:0] cycle_count;

    modport master (
        output light, clear_fault,
        input  lamp, fault, fault_code, cycle_count
    );

    modport slave (
        input  light, clear_fault,
        output lamp, fault, fault_code, cycle_count
    );
endinterface

// File: rtl/lamp_guard.sv
// Lamp sequence guard: passes a legal RED->GREEN->YELLOW cycle through,
// latches illegal codes, transitions and dwell timeouts as a flashing fault.
module lamp_guard #(
    parameter int unsigned MAX_DWELL  = 15,
    parameter int unsigned FLASH_HALF = 4
) (
    input  logic        clk,
    input  logic        rst,
    lamp_guard_if.slave bus
);
    typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] GREEN  = 3'b010;
    localparam logic [0:2] YELLOW = 3'b001;
    localparam logic [0:2] DARK   = 3'b000;

    localparam logic [7:0] DWELL_MAX  = 8'(MAX_DWELL);
    localparam logic [7:0] DWELL_SAT  = 8'(MAX_DWELL + 1);
    localparam logic [8:0] FLASH_H    = 9'(FLASH_HALF);
    localparam logic [8:0] FLASH_LAST = 9'(2 * FLASH_HALF - 1);

    state_t     state_q;
    logic [0:2] light_q;
    logic [0:2] prev_q;
    logic [0:2] lamp_q;
    logic       fault_q;
    logic [1:0] code_q;
    logic [7:0] count_q;
    logic [7:0] dwell_q;
    logic [8:0] flash_q;

    logic       legal;
    logic       same;
    logic [0:2] succ;
    logic [7:0] dwell_d;
    logic [8:0] flash_d;
    logic [1:0] flt_code;

    always_comb begin
        unique case (prev_q)
            RED:     succ = GREEN;
            GREEN:   succ = YELLOW;
            default: succ = RED;
        endcase
        legal   = (light_q == RED) || (light_q == GREEN)
                  || (light_q == YELLOW);
        same    = (light_q == prev_q);
        dwell_d = (dwell_q >= DWELL_SAT) ? DWELL_SAT : dwell_q + 8'd1;
        flash_d = (flash_q == FLASH_LAST) ? 9'd0 : flash_q + 9'd1;
        // Priority: illegal code, then illegal step, then timeout
        flt_code = 2'd0;
        if (!legal)
            flt_code = 2'd1;
        else if (!same && light_q != succ)
            flt_code = 2'd2;
        else if (same && dwell_d > DWELL_MAX)
            flt_code = 2'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            light_q <= DARK;
            prev_q  <= RED;
            lamp_q  <= RED;
            fault_q <= 1'b0;
            code_q  <= 2'd0;
            count_q <= 8'd0;
            dwell_q <= 8'd0;
            flash_q <= 9'd0;
        end else begin
            light_q <= bus.light;
            unique case (state_q)
                S_INIT: begin
                    if (legal) begin
                        prev_q  <= light_q;
                        dwell_q <= 8'd1;
                        lamp_q  <= light_q;
                        state_q <= S_RUN;
                    end else begin
                        lamp_q <= RED;
                    end
                end
                S_RUN: begin
                    if (flt_code != 2'd0) begin
                        state_q <= S_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= flt_code;
                        lamp_q  <= YELLOW;
                        flash_q <= 9'd1;
                    end else if (same) begin
                        dwell_q <= dwell_d;
                        lamp_q  <= light_q;
                    end else begin
                        if (prev_q == RED)
                            count_q <= count_q + 8'd1;
                        prev_q  <= light_q;
                        dwell_q <= 8'd1;
                        lamp_q  <= light_q;
                    end
                end
                S_FAULT: begin
                    if (bus.clear_fault) begin
                        state_q <= S_INIT;
                        fault_q <= 1'b0;
                        code_q  <= 2'd0;
                        flash_q <= 9'd0;
                        dwell_q <= 8'd0;
                        lamp_q  <= RED;
                    end else begin
                        lamp_q  <= (flash_q < FLASH_H) ? YELLOW : DARK;
                        flash_q <= flash_d;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign bus.lamp        = lamp_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
    assign bus.cycle_count = count_q;
endmodule

// File: tb/tb_lamp_guard.sv
// Randomized and directed bench for lamp_guard against a
// cycle-level model built from the lamp sequencing rules.
module tb_lamp_guard;
    localparam int MD = 4;
    localparam int FH = 2;

    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] GREEN  = 3'b010;
    localparam logic [0:2] YELLOW = 3'b001;
    localparam logic [0:2] DARK   = 3'b000;

    localparam int M_INIT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lamp_guard_if bus ();

    lamp_guard #(
        .MAX_DWELL (MD),
        .FLASH_HALF(FH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int         m_mode;
    logic [0:2] m_lq;
    logic [0:2] m_prev;
    int         m_run;
    int         m_code;
    int         m_cnt;
    int         m_ft;
    logic [0:2] m_lamp;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [0:2] l);
        return (l == RED) || (l == GREEN) || (l == YELLOW);
    endfunction

    function automatic logic [0:2] next_of(input logic [0:2] l);
        if (l == RED)   return GREEN;
        if (l == GREEN) return YELLOW;
        return RED;
    endfunction

    task automatic m_reset();
        m_mode = M_INIT;
        m_lq   = DARK;
        m_prev = RED;
        m_run  = 0;
        m_code = 0;
        m_cnt  = 0;
        m_ft   = 0;
        m_lamp = RED;
    endtask

    task automatic m_fault(input int k);
        m_mode = M_FAULT;
        m_code = k;
        m_ft   = 0;
        m_lamp = YELLOW;
    endtask

    task automatic m_edge(input logic [0:2] l, input logic c);
        logic [0:2] s;
        s    = m_lq;
        m_lq = l;
        if (m_mode == M_INIT) begin
            if (is_legal(s)) begin
                m_prev = s;
                m_run  = 1;
                m_mode = M_RUN;
                m_lamp = s;
            end else begin
                m_lamp = RED;
            end
        end else if (m_mode == M_RUN) begin
            if (!is_legal(s)) begin
                m_fault(1);
            end else if (s == m_prev) begin
                if (m_run + 1 > MD) begin
                    m_fault(3);
                end else begin
                    m_run++;
                    m_lamp = s;
                end
            end else if (s == next_of(m_prev)) begin
                if (m_prev == RED) m_cnt = (m_cnt + 1) % 256;
                m_prev = s;
                m_run  = 1;
                m_lamp = s;
            end else begin
                m_fault(2);
            end
        end else begin
            if (c) begin
                m_mode = M_INIT;
                m_code = 0;
                m_lamp = RED;
            end else begin
                m_ft++;
                m_lamp = ((m_ft / FH) % 2 == 0) ? YELLOW : DARK;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".lamp"}, int'(bus.lamp), int'(m_lamp));
        check({tag, ".fault"}, int'(bus.fault), (m_mode == M_FAULT) ? 1 : 0);
        check({tag, ".code"}, int'(bus.fault_code), m_code);
        check({tag, ".count"}, int'(bus.cycle_count), m_cnt);
    endtask

    task automatic step(input logic [0:2] l, input logic c, input string tag);
        bus.light       = l;
        bus.clear_fault = c;
        @(posedge clk);
        #1;
        m_edge(l, c);
        check_all(tag);
    endtask

    // reset asserted mid-cycle; outputs must change before the next edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("arst.lamp", int'(bus.lamp), int'(RED));
        check("arst.fault", int'(bus.fault), 0);
        check("arst.code", int'(bus.fault_code), 0);
        check("arst.count", int'(bus.cycle_count), 0);
        m_reset();
        bus.light       = DARK;
        bus.clear_fault = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [0:2] cur;
        int         r;
        bus.light       = DARK;
        bus.clear_fault = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        check_all("por");
        rst = 1'b0;

        // legal sequence, three RED->GREEN transitions
        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0:       step(GREEN, 1'b0, "seq");
                1:       step(YELLOW, 1'b0, "seq");
                default: step(RED, 1'b0, "seq");
            endcase
        end
        step(GREEN, 1'b0, "seq");
        check("seq.cnt3", int'(bus.cycle_count), 3);

        // illegal transition GREEN->RED and flash pattern
        do_reset();
        step(GREEN, 1'b0, "ill");
        step(RED, 1'b0, "ill");
        step(RED, 1'b0, "ill");
        check("ill.code2", int'(bus.fault_code), 2);
        check("ill.lamp0", int'(bus.lamp), int'(YELLOW));
        step(GREEN, 1'b0, "ill");
        check("ill.lamp1", int'(bus.lamp), int'(YELLOW));
        step(YELLOW, 1'b0, "ill");
        check("ill.lamp2", int'(bus.lamp), int'(DARK));
        step(RED, 1'b0, "ill");
        check("ill.lamp3", int'(bus.lamp), int'(DARK));
        step(RED, 1'b0, "ill");
        check("ill.lamp4", int'(bus.lamp), int'(YELLOW));

        // dwell timeout then clear
        do_reset();
        for (int i = 0; i < 5; i++) step(GREEN, 1'b0, "dwl");
        step(DARK, 1'b0, "dwl");
        check("dwl.code3", int'(bus.fault_code), 3);
        step(DARK, 1'b1, "dwl");
        check("clr.fault", int'(bus.fault), 0);
        check("clr.code", int'(bus.fault_code), 0);
        check("clr.lamp", int'(bus.lamp), int'(RED));
        step(DARK, 1'b0, "clr");

        // illegal code wins over a due timeout
        do_reset();
        for (int i = 0; i < 4; i++) step(GREEN, 1'b0, "pri");
        step(3'b110, 1'b1, "pri");
        step(DARK, 1'b1, "pri");
        check("pri.code1", int'(bus.fault_code), 1);

        // 256 RED->GREEN transitions wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(GREEN, 1'b0, "wrap");
            step(YELLOW, 1'b0, "wrap");
            step(RED, 1'b0, "wrap");
        end
        step(GREEN, 1'b0, "wrap");
        step(YELLOW, 1'b0, "wrap");
        step(YELLOW, 1'b0, "wrap");
        check("wrap.cnt0", int'(bus.cycle_count), 0);
        do_reset();

        // randomized traffic
        cur = GREEN;
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 8)
                cur = next_of(cur);
            else if (r < 13)
                cur = cur;
            else if (r < 14)
                cur = 3'($urandom_range(0, 7));
            else
                cur = 3'(1 << $urandom_range(0, 2));
            step(cur, ($urandom_range(0, 7) == 0), "rnd");
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
